store_commit_buffer: RTL and testbench
======================================

# store_commit_buffer

Holds committed stores leaving the store queue until the D-cache write port accepts them. It accepts one committed store per cycle, merges byte writes into the youngest entry when the block addresses match, and drains entries in program order over a req/ack handshake. It also gives the load pipe byte-granular forwarding from entries that have not yet been written to the cache. It sits between store-queue commit and the D-cache write port.

## Interface
Parameters:
- ENTRY_NUM, 4, buffer depth; power of two, ≥2
- ENABLE_MERGE, 1, enables write-combining into the youngest entry

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- enqValid  in  1  a committed store is presented
- enqReady  out  1  buffer can accept; equals !full, from registered state only
- enqAddr  in  LSQ_BlockAddrPath  block address
- enqData  in  LSQ_BlockDataPath  store data, already byte-aligned in the block
- enqByteWE  in  LSQ_WordByteEnablePath  byte write enables
- dcReq  out  1  head entry is valid for the D-cache
- dcAddr  out  PhyAddrPath  LSQ_ToFullAddrFromBlockAddr(head address)
- dcData  out  LSQ_BlockDataPath  head data
- dcByteWE  out  LSQ_WordByteEnablePath  head byte enables
- dcAck  in  1  D-cache accepted the head this cycle
- ldAddr  in  LSQ_BlockAddrPath  load block address for forwarding
- fwdByteHit  out  LSQ_WordByteEnablePath  bytes supplied by the buffer
- fwdData  out  LSQ_BlockDataPath  forwarded bytes; don't-care where fwdByteHit=0
- empty  out  1  no valid entries
- count  out  $clog2(ENTRY_NUM)+1  valid entries

## Operation
- The buffer is a circular FIFO with head/tail pointers of $clog2(ENTRY_NUM) bits plus a registered count. Pointers wrap modulo ENTRY_NUM.
- Enqueue fires on enqValid && enqReady.
- Merge rule: when ENABLE_MERGE=1, count≥2, and enqAddr equals the address of the youngest entry (tail-1), the store merges into that entry.
  - Bytes with enqByteWE set overwrite the entry's data; byteWE is ORed.
  - count and tail do not change.
- A merge never targets the head, because the head may be under request. With count==1 the store always allocates a new entry.
- Otherwise the store is written at tail, and tail and count increment.
- Drain: dcReq = !empty. dcAddr, dcData and dcByteWE come from the head.
  - Head contents must not change while dcReq=1 (guaranteed by the merge rule).
  - On dcReq && dcAck the head pops: head increments and count decrements.
  - dcAck while dcReq=0 is ignored.
- Simultaneous allocate and pop: count is unchanged and both pointers advance.
- Simultaneous merge and pop is legal only when count≥3 after the rule above. Otherwise the store allocates.
- Full with dcAck in the same cycle: enqReady stays 0. There is no combinational ack→ready path.
- Forwarding (combinational on ldAddr):
  - For each byte b, fwdByteHit[b]=1 if any valid entry has address==ldAddr and byteWE[b]=1.
  - fwdData byte b comes from the youngest such entry, by age order from head.
  - The forwarding view uses registered state, so an entry popping this cycle still forwards. A store enqueued this cycle is not visible until the next cycle.
- Reset: head=tail=count=0, all valid cleared. Outputs: dcReq=0, empty=1, count=0, enqReady=1, fwdByteHit=0.
- Reset asserted mid-handshake drops the outstanding request. Committed stores are lost; the system issues reset only at whole-core reset.

## Timing
- Enqueue→dcReq: 1 cycle (entry visible the cycle after enqueue).
- Enqueue→forwarding visible: 1 cycle.
- Pop on dcAck takes effect next cycle. Back-to-back acks drain one entry per cycle.
- Merge is visible to dcData/fwdData the next cycle.
- enqReady and empty are functions of registered count only.

## Structure
- Add StoreCommitBufferEntry {valid, address: LSQ_BlockAddrPath, data: LSQ_BlockDataPath, byteWE: LSQ_WordByteEnablePath} to LoadStoreUnitTypes.
- Add localparam STORE_COMMIT_BUFFER_ENTRY_NUM to LoadStoreUnitTypes, configured from MicroArchConf.
- Add StoreCommitBufferIndexPath and StoreCommitBufferCountPath typedefs to LoadStoreUnitTypes.
- Sub-module store_commit_forward_picker (combinational): age-ordered per-byte youngest-match select. Inputs are the entry array, head and ldAddr. Outputs are fwdByteHit and fwdData.

## Test plan
- After reset: dcReq=0, empty=1, enqReady=1, fwdByteHit=0.
- Enq A=0x100, data=0xAABBCCDD, WE=0xF; hold dcAck=0 → next cycle dcReq=1, dcAddr=0x400, dcByteWE=0xF. Assert dcAck 3 cycles later → empty=1 the following cycle.
- Merge:
  - Enq A=0x100 WE=0x1 data=0x11, then A=0x200 WE=0x3 data=0x2222, then A=0x200 WE=0xC data=0x33330000, with dcAck=0.
  - Expect count=2, second entry data=0x33332222, WE=0xF.
  - Repeat with count==1 (A=0x200 twice) → count=2, no merge.
- Fill 4 entries with dcAck=0 → enqReady=0. Assert enqValid+dcAck together → no enqueue, count=3 next cycle, enqReady=1.
- Forwarding: entries A=0x80 WE=0x3 data=0x0000BEEF (old), then A=0x80 WE=0x6 data=0x00CAFE00 (new, separate entry since the first is head). ldAddr=0x80 → fwdByteHit=0x7, fwdData[23:0]=0xCAFEEF.
- Wrap: 10 enqueue/ack pairs with random ack gaps. The dcAddr sequence must equal the enqueue order; a scoreboard checks no loss or duplication.

Source files
------------

// File: rtl/store_commit_buffer_pkg.sv
// Shared types for the store commit buffer: block geometry, entry layout, address helper.
package store_commit_buffer_pkg;

  localparam int unsigned PHY_ADDR_WIDTH                 = 32;
  localparam int unsigned LSQ_BLOCK_BYTE_NUM             = 4;
  localparam int unsigned LSQ_BLOCK_BYTE_WIDTH_BIT       = $clog2(LSQ_BLOCK_BYTE_NUM);
  localparam int unsigned LSQ_BLOCK_WIDTH                = 8 * LSQ_BLOCK_BYTE_NUM;
  localparam int unsigned LSQ_BLOCK_ADDR_WIDTH           = PHY_ADDR_WIDTH - LSQ_BLOCK_BYTE_WIDTH_BIT;
  localparam int unsigned STORE_COMMIT_BUFFER_ENTRY_NUM  = 4;
  localparam int unsigned STORE_COMMIT_BUFFER_INDEX_BITS = $clog2(STORE_COMMIT_BUFFER_ENTRY_NUM);

  typedef logic [PHY_ADDR_WIDTH-1:0]                 PhyAddrPath;
  typedef logic [LSQ_BLOCK_ADDR_WIDTH-1:0]           LSQ_BlockAddrPath;
  typedef logic [LSQ_BLOCK_WIDTH-1:0]                LSQ_BlockDataPath;
  typedef logic [LSQ_BLOCK_BYTE_NUM-1:0]             LSQ_WordByteEnablePath;
  typedef logic [STORE_COMMIT_BUFFER_INDEX_BITS-1:0] StoreCommitBufferIndexPath;
  typedef logic [STORE_COMMIT_BUFFER_INDEX_BITS:0]   StoreCommitBufferCountPath;

  typedef struct packed {
    logic                  valid;
    LSQ_BlockAddrPath      address;
    LSQ_BlockDataPath      data;
    LSQ_WordByteEnablePath byteWE;
  } StoreCommitBufferEntry;

  // Block address to byte address: append zero byte-offset bits.
  function automatic PhyAddrPath LSQ_ToFullAddrFromBlockAddr(input LSQ_BlockAddrPath addr);
    return {addr, {LSQ_BLOCK_BYTE_WIDTH_BIT{1'b0}}};
  endfunction

endpackage

// File: rtl/store_commit_forward_picker.sv
// Per-byte youngest-match forwarding select over the buffer, walked in age order from head.
module store_commit_forward_picker
  import store_commit_buffer_pkg::*;
#(
  parameter int unsigned ENTRY_NUM = STORE_COMMIT_BUFFER_ENTRY_NUM,
  localparam int unsigned IDX_W    = $clog2(ENTRY_NUM)
) (
  input  StoreCommitBufferEntry [ENTRY_NUM-1:0] entries_i,
  input  logic [IDX_W-1:0]                      head_i,
  input  LSQ_BlockAddrPath                      ld_addr_i,
  output LSQ_WordByteEnablePath                 fwd_byte_hit_o,
  output LSQ_BlockDataPath                      fwd_data_o
);

  logic [IDX_W-1:0] idx;

  // Oldest to youngest: later matches overwrite earlier ones, so the youngest wins per byte.
  always_comb begin
    fwd_byte_hit_o = '0;
    fwd_data_o     = '0;
    idx            = '0;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      idx = head_i + IDX_W'(i);
      if (entries_i[idx].valid && (entries_i[idx].address == ld_addr_i)) begin
        for (int unsigned b = 0; b < LSQ_BLOCK_BYTE_NUM; b++) begin
          if (entries_i[idx].byteWE[b]) begin
            fwd_byte_hit_o[b]       = 1'b1;
            fwd_data_o[b*8 +: 8]    = entries_i[idx].data[b*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/store_commit_buffer.sv
// Store commit buffer: in-order FIFO of committed stores draining to the D-cache,
// with write-combining into the youngest non-head entry and load forwarding.
module store_commit_buffer
  import store_commit_buffer_pkg::*;
#(
  parameter int unsigned ENTRY_NUM    = STORE_COMMIT_BUFFER_ENTRY_NUM,
  parameter bit          ENABLE_MERGE = 1'b1,
  localparam int unsigned IDX_W       = $clog2(ENTRY_NUM),
  localparam int unsigned CNT_W       = IDX_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enqValid,
  output logic                  enqReady,
  input  LSQ_BlockAddrPath      enqAddr,
  input  LSQ_BlockDataPath      enqData,
  input  LSQ_WordByteEnablePath enqByteWE,
  output logic                  dcReq,
  output PhyAddrPath            dcAddr,
  output LSQ_BlockDataPath      dcData,
  output LSQ_WordByteEnablePath dcByteWE,
  input  logic                  dcAck,
  input  LSQ_BlockAddrPath      ldAddr,
  output LSQ_WordByteEnablePath fwdByteHit,
  output LSQ_BlockDataPath      fwdData,
  output logic                  empty,
  output logic [CNT_W-1:0]      count
);

  StoreCommitBufferEntry [ENTRY_NUM-1:0] entries_q, entries_d;
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             pop;
  logic             enq_fire;
  logic             merge_ok;
  logic             alloc;
  logic [IDX_W-1:0] youngest;

  // Status and head view, all from registered state.
  assign empty    = (count_q == '0);
  assign enqReady = (count_q != CNT_W'(ENTRY_NUM));
  assign dcReq    = !empty;
  assign dcAddr   = LSQ_ToFullAddrFromBlockAddr(entries_q[head_q].address);
  assign dcData   = entries_q[head_q].data;
  assign dcByteWE = entries_q[head_q].byteWE;
  assign count    = count_q;

  // Next-state: pop on ack, then merge into youngest or allocate at tail.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    youngest  = tail_q - IDX_W'(1);
    pop       = dcReq && dcAck;
    enq_fire  = enqValid && enqReady;
    // The youngest entry must never be the head (current or next), so require
    // at least one other entry in front of it after any pop this cycle.
    merge_ok  = ENABLE_MERGE
             && entries_q[youngest].valid
             && (entries_q[youngest].address == enqAddr)
             && (pop ? (count_q >= CNT_W'(3)) : (count_q >= CNT_W'(2)));
    alloc     = enq_fire && !merge_ok;

    if (pop) begin
      entries_d[head_q].valid = 1'b0;
      head_d                  = head_q + IDX_W'(1);
    end

    if (enq_fire) begin
      if (merge_ok) begin
        for (int unsigned b = 0; b < LSQ_BLOCK_BYTE_NUM; b++) begin
          if (enqByteWE[b]) begin
            entries_d[youngest].data[b*8 +: 8] = enqData[b*8 +: 8];
          end
        end
        entries_d[youngest].byteWE = entries_q[youngest].byteWE | enqByteWE;
      end else begin
        entries_d[tail_q] = '{valid: 1'b1, address: enqAddr, data: enqData, byteWE: enqByteWE};
        tail_d            = tail_q + IDX_W'(1);
      end
    end

    count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  store_commit_forward_picker #(
    .ENTRY_NUM (ENTRY_NUM)
  ) u_picker (
    .entries_i      (entries_q),
    .head_i         (head_q),
    .ld_addr_i      (ldAddr),
    .fwd_byte_hit_o (fwdByteHit),
    .fwd_data_o     (fwdData)
  );

endmodule

// File: tb/tb_store_commit_buffer.sv
// Scoreboard bench for store_commit_buffer: a queue of pending stores models the buffer.
module tb_store_commit_buffer;
  import store_commit_buffer_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned CNT_W = $clog2(N) + 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  enqValid = 1'b0;
  logic                  enqReady;
  LSQ_BlockAddrPath      enqAddr = '0;
  LSQ_BlockDataPath      enqData = '0;
  LSQ_WordByteEnablePath enqByteWE = '0;
  logic                  dcReq;
  PhyAddrPath            dcAddr;
  LSQ_BlockDataPath      dcData;
  LSQ_WordByteEnablePath dcByteWE;
  logic                  dcAck = 1'b0;
  LSQ_BlockAddrPath      ldAddr = '0;
  LSQ_WordByteEnablePath fwdByteHit;
  LSQ_BlockDataPath      fwdData;
  logic                  empty;
  logic [CNT_W-1:0]      count;

  store_commit_buffer #(.ENTRY_NUM(N), .ENABLE_MERGE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .enqValid(enqValid), .enqReady(enqReady), .enqAddr(enqAddr), .enqData(enqData),
    .enqByteWE(enqByteWE),
    .dcReq(dcReq), .dcAddr(dcAddr), .dcData(dcData), .dcByteWE(dcByteWE), .dcAck(dcAck),
    .ldAddr(ldAddr), .fwdByteHit(fwdByteHit), .fwdData(fwdData),
    .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    LSQ_BlockAddrPath      addr;
    LSQ_BlockDataPath      data;
    LSQ_WordByteEnablePath we;
  } ment_t;

  ment_t mq[$];          // pending stores, oldest first
  int    tests = 0;
  int    fails = 0;
  bit    mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference enqueue on the post-pop queue: a store joins the last pending store
  // when that store has another pending store ahead of it and the block matches.
  task automatic model_enq(input LSQ_BlockAddrPath a, input LSQ_BlockDataPath d,
                           input LSQ_WordByteEnablePath w);
    ment_t e;
    if (mq.size() >= 2 && mq[mq.size()-1].addr == a) begin
      e = mq.pop_back();
      for (int b = 0; b < 4; b++) if (w[b]) e.data[b*8 +: 8] = d[b*8 +: 8];
      e.we = e.we | w;
      mq.push_back(e);
    end else begin
      e.addr = a; e.data = d; e.we = w;
      mq.push_back(e);
    end
  endtask

  // Monitor: compare every visible output against the model, retire on handshake.
  always @(negedge clk) begin : monitor
    int                    sz;
    LSQ_WordByteEnablePath eh;
    LSQ_BlockDataPath      ed;
    LSQ_BlockDataPath      mask;
    if (mon_en && !rst) begin
      sz = mq.size();
      check("count",    64'(count),    64'(sz));
      check("empty",    64'(empty),    64'(sz == 0));
      check("enqReady", 64'(enqReady), 64'(sz < N));
      check("dcReq",    64'(dcReq),    64'(sz != 0));
      if (sz > 0) begin
        check("dcAddr",   64'(dcAddr),   64'(PhyAddrPath'(mq[0].addr) * 4));
        check("dcData",   64'(dcData),   64'(mq[0].data));
        check("dcByteWE", 64'(dcByteWE), 64'(mq[0].we));
      end
      eh = '0; ed = '0; mask = '0;
      foreach (mq[i]) begin
        if (mq[i].addr == ldAddr) begin
          for (int b = 0; b < 4; b++) begin
            if (mq[i].we[b]) begin
              eh[b] = 1'b1;
              ed[b*8 +: 8] = mq[i].data[b*8 +: 8];
            end
          end
        end
      end
      for (int b = 0; b < 4; b++) if (eh[b]) mask[b*8 +: 8] = 8'hFF;
      check("fwdByteHit", 64'(fwdByteHit), 64'(eh));
      check("fwdData",    64'(fwdData & mask), 64'(ed));
      if (dcAck && sz > 0) void'(mq.pop_front());
    end
  end

  // One cycle of stimulus; called at posedge+1, returns at next posedge+1.
  task automatic step(input bit v, input LSQ_BlockAddrPath a, input LSQ_BlockDataPath d,
                      input LSQ_WordByteEnablePath w, input bit ack, input LSQ_BlockAddrPath ld);
    bit fire;
    enqValid = v; enqAddr = a; enqData = d; enqByteWE = w; dcAck = ack; ldAddr = ld;
    fire = v && (mq.size() < N);
    @(posedge clk); #1;
    if (fire) model_enq(a, d, w);
    enqValid = 1'b0; dcAck = 1'b0;
  endtask

  task automatic idle(input bit ack, input LSQ_BlockAddrPath ld);
    step(1'b0, '0, '0, '0, ack, ld);
  endtask

  task automatic do_reset();
    rst = 1'b1; enqValid = 1'b0; dcAck = 1'b0;
    mq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  LSQ_BlockAddrPath pool [4];

  initial begin
    pool[0] = 30'h80; pool[1] = 30'h100; pool[2] = 30'h200; pool[3] = 30'h300;

    // Reset state
    @(posedge clk); #1;
    rst = 1'b0; ldAddr = 30'h100;
    mon_en = 1'b1;
    check("rst_dcReq",    64'(dcReq),      64'd0);
    check("rst_empty",    64'(empty),      64'd1);
    check("rst_enqReady", 64'(enqReady),   64'd1);
    check("rst_fwdHit",   64'(fwdByteHit), 64'd0);

    // Single store, held, then drained
    step(1'b1, 30'h100, 32'hAABBCCDD, 4'hF, 1'b0, 30'h100);
    check("one_dcReq",  64'(dcReq),    64'd1);
    check("one_dcAddr", 64'(dcAddr),   64'h400);
    check("one_dcWE",   64'(dcByteWE), 64'hF);
    idle(1'b0, 30'h100);
    idle(1'b0, 30'h100);
    idle(1'b1, 30'h100);
    check("one_drained", 64'(empty), 64'd1);

    // Merge into youngest non-head entry
    do_reset();
    step(1'b1, 30'h100, 32'h00000011, 4'h1, 1'b0, 30'h200);
    step(1'b1, 30'h200, 32'h00002222, 4'h3, 1'b0, 30'h200);
    step(1'b1, 30'h200, 32'h33330000, 4'hC, 1'b0, 30'h200);
    check("merge_count",  64'(count),      64'd2);
    check("merge_fwdHit", 64'(fwdByteHit), 64'hF);
    check("merge_fwdDat", 64'(fwdData),    64'h33332222);

    // count==1: same address allocates instead of merging into head
    do_reset();
    step(1'b1, 30'h200, 32'h00002222, 4'h3, 1'b0, 30'h200);
    step(1'b1, 30'h200, 32'h33330000, 4'hC, 1'b0, 30'h200);
    check("nomerge_count", 64'(count),    64'd2);
    check("nomerge_head",  64'(dcByteWE), 64'h3);

    // Full, then enqueue+ack in the same cycle: no enqueue
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, pool[i], 32'(i + 1), 4'hF, 1'b0, 30'h0);
    check("full_ready", 64'(enqReady), 64'd0);
    check("full_count", 64'(count),    64'd4);
    step(1'b1, 30'h3FF, 32'hDEAD, 4'hF, 1'b1, 30'h0);
    check("fullack_count", 64'(count),    64'd3);
    check("fullack_ready", 64'(enqReady), 64'd1);
    check("fullack_head",  64'(dcAddr),   64'h400);

    // Forwarding: younger entry wins per byte
    do_reset();
    step(1'b1, 30'h80, 32'h0000BEEF, 4'h3, 1'b0, 30'h80);
    step(1'b1, 30'h80, 32'h00CAFE00, 4'h6, 1'b0, 30'h80);
    check("fwd_count", 64'(count),              64'd2);
    check("fwd_hit",   64'(fwdByteHit),         64'h7);
    check("fwd_data",  64'(fwdData[23:0]),      64'hCAFEEF);

    // Randomized traffic with wrap-around; monitor checks order and contents
    do_reset();
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           pool[$urandom_range(0, 3)], $urandom(), 4'($urandom_range(1, 15)),
           ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0,
           pool[$urandom_range(0, 3)]);
    end

    // Drain everything left
    for (int c = 0; c < 3 * N && mq.size() > 0; c++) idle(1'b1, 30'h80);
    check("final_empty", 64'(empty), 64'd1);
    check("final_model", 64'(mq.size()), 64'd0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
